// File: rtl/tmr_fault_monitor.sv
// TMR fault monitor: tracks replica disagreement statistics, classifies
// persistent replica failures, drives the resync handshake and escalates
// to a sticky halt once redundancy is lost.
module tmr_fault_monitor #(
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned PERSIST_THRESH  = 4,
  parameter int unsigned RECOVER_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_i,
  input  logic                 fault_a_i,
  input  logic                 fault_b_i,
  input  logic                 fault_c_i,
  input  logic                 system_fault_i,
  input  logic                 resync_ack_i,
  input  logic                 clear_i,
  output logic                 resync_req_o,
  output logic [2:0]           replica_ok_o,
  output logic                 halt_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] fault_cnt_a_o,
  output logic [CNT_WIDTH-1:0] fault_cnt_b_o,
  output logic [CNT_WIDTH-1:0] fault_cnt_c_o,
  output logic [CNT_WIDTH-1:0] sys_fault_cnt_o
);

  localparam int unsigned CW = $clog2(PERSIST_THRESH + 1);
  localparam int unsigned TW = (RECOVER_TIMEOUT > 1) ? $clog2(RECOVER_TIMEOUT) : 1;

  localparam logic [1:0] S_NORMAL   = 2'd0;
  localparam logic [1:0] S_RECOVER  = 2'd1;
  localparam logic [1:0] S_DEGRADED = 2'd2;
  localparam logic [1:0] S_FAILSAFE = 2'd3;

  logic [1:0]           state_q, state_n;
  logic [2:0]           ok_q, ok_n, ok_upd;
  logic                 req_q, req_n;
  logic                 halt_q, halt_n;
  logic [TW-1:0]        tmo_q, tmo_n;
  logic [CW-1:0]        consec_q   [3];
  logic [CW-1:0]        consec_n   [3];
  logic [CW-1:0]        consec_upd [3];
  logic [CNT_WIDTH-1:0] tot_q      [4];
  logic [CNT_WIDTH-1:0] tot_n      [4];
  logic [3:0]           hit;
  logic [2:0]           new_fail;
  logic [1:0]           n_failed;
  logic                 lost_redundancy;

  // Per-replica hit detection, saturating totals and consecutive tracking
  always_comb begin
    hit = {sample_i & system_fault_i, sample_i & fault_c_i,
           sample_i & fault_b_i, sample_i & fault_a_i};
    for (int i = 0; i < 4; i++) begin
      tot_n[i] = tot_q[i];
      if (hit[i] && (tot_q[i] != '1)) tot_n[i] = tot_q[i] + CNT_WIDTH'(1);
    end
    for (int i = 0; i < 3; i++) begin
      consec_upd[i] = consec_q[i];
      if (hit[i]) begin
        if (consec_q[i] != CW'(PERSIST_THRESH)) consec_upd[i] = consec_q[i] + CW'(1);
      end else if (sample_i) begin
        consec_upd[i] = '0;
      end
      new_fail[i] = ok_q[i] & hit[i] & (consec_upd[i] == CW'(PERSIST_THRESH));
    end
    ok_upd          = ok_q & ~new_fail;
    n_failed        = {1'b0, ~ok_upd[0]} + {1'b0, ~ok_upd[1]} + {1'b0, ~ok_upd[2]};
    lost_redundancy = hit[3] | (n_failed >= 2'd2);
  end

  // Next-state and registered-output decode, in edge priority order
  always_comb begin
    state_n = state_q;
    ok_n    = ok_upd;
    tmo_n   = tmo_q;
    for (int i = 0; i < 3; i++) consec_n[i] = consec_upd[i];

    if (clear_i) begin
      state_n = S_NORMAL;
      ok_n    = 3'b111;
      tmo_n   = '0;
      for (int i = 0; i < 3; i++) consec_n[i] = '0;
    end else begin
      case (state_q)
        S_NORMAL: begin
          if (lost_redundancy) begin
            state_n = S_FAILSAFE;
          end else if (|new_fail) begin
            state_n = S_RECOVER;
            tmo_n   = '0;
          end
        end
        S_RECOVER: begin
          if (lost_redundancy) begin
            state_n = S_FAILSAFE;
          end else if (resync_ack_i) begin
            state_n = S_NORMAL;
            ok_n    = 3'b111;
            for (int i = 0; i < 3; i++) if (!ok_q[i]) consec_n[i] = '0;
          end else if (tmo_q == TW'(RECOVER_TIMEOUT - 1)) begin
            state_n = S_DEGRADED;
          end else begin
            tmo_n = tmo_q + TW'(1);
          end
        end
        S_DEGRADED: begin
          if (lost_redundancy || (|new_fail)) state_n = S_FAILSAFE;
        end
        default: state_n = S_FAILSAFE;
      endcase
    end

    req_n  = (state_n == S_RECOVER);
    halt_n = (state_n == S_FAILSAFE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_NORMAL;
      ok_q    <= 3'b111;
      req_q   <= 1'b0;
      halt_q  <= 1'b0;
      tmo_q   <= '0;
      for (int i = 0; i < 3; i++) consec_q[i] <= '0;
      for (int i = 0; i < 4; i++) tot_q[i] <= '0;
    end else begin
      state_q <= state_n;
      ok_q    <= ok_n;
      req_q   <= req_n;
      halt_q  <= halt_n;
      tmo_q   <= tmo_n;
      for (int i = 0; i < 3; i++) consec_q[i] <= consec_n[i];
      for (int i = 0; i < 4; i++) tot_q[i] <= tot_n[i];
    end
  end

  assign state_o         = state_q;
  assign replica_ok_o    = ok_q;
  assign resync_req_o    = req_q;
  assign halt_o          = halt_q;
  assign fault_cnt_a_o   = tot_q[0];
  assign fault_cnt_b_o   = tot_q[1];
  assign fault_cnt_c_o   = tot_q[2];
  assign sys_fault_cnt_o = tot_q[3];

endmodule
